// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and line geometry for the memory arbiter.
package mem_arb_pkg;
    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_BYTES = 2;
    typedef enum logic [1:0] {ARB_IDLE, ARB_I_FILL, ARB_D_FILL, ARB_D_WRITE} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache requester, memory and return signals of the memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic i_req;
    logic [ADDR_W-1:0] i_addr;
    logic d_req;
    logic d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic mem_en;
    logic mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic mem_rvalid;
    logic i_grant;
    logic d_grant;
    logic i_rvalid;
    logic d_rvalid;
    logic [DATA_W-1:0] rdata;
    logic i_done;
    logic d_done;
    modport slave (
        input i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant, i_rvalid, d_rvalid,
        rdata, i_done, d_done
    );
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
        input mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant, i_rvalid, d_rvalid,
        rdata, i_done, d_done
    );
endinterface

// File: rtl/arb_word_counter.sv
// arb_word_counter: word counter with increment, clear and terminal-count flag.
module arb_word_counter #(
    parameter int CNT_W = 4,
    parameter int TC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
    assign tc = cnt == CNT_W'(TC);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants main memory to I-cache fills, D-cache fills or D-cache stores.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate the winner on simultaneous requests.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS = WORDS_PER_LINE,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst,
    mem_arbiter_if.slave bus
);
    arb_state_t state, nxt;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wdata;
    logic [CNT_W-1:0] issue_cnt, ret_cnt;
    logic issue_tc, ret_tc, fill, ret, done, arb, req_i, req_d, pick_d, pick_i;

    assign fill = state == ARB_I_FILL || state == ARB_D_FILL;
    assign ret = fill && bus.mem_rvalid && !ret_tc;
    assign done = (ret && ret_cnt == CNT_W'(WORDS - 1)) || state == ARB_D_WRITE;
    assign arb = state == ARB_IDLE || done;
    // The finishing owner still holds its request during done; mask it so it is not re-granted.
    assign req_i = bus.i_req && !(done && state == ARB_I_FILL);
    assign req_d = bus.d_req && !(done && state != ARB_I_FILL);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;
    assign pick_d = req_d && (!req_i || !last_d);
    always_ff @(posedge clk) begin
        if (rst) last_d <= 1'b0;
        else if (arb && (pick_d || pick_i)) last_d <= pick_d;
    end
`else
    assign pick_d = req_d;
`endif
    assign pick_i = req_i && !pick_d;
    assign nxt = pick_d ? (bus.d_wr ? ARB_D_WRITE : ARB_D_FILL) : (pick_i ? ARB_I_FILL : ARB_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            base <= '0;
            wdata <= '0;
        end else if (arb) begin
            state <= nxt;
            base <= pick_d ? bus.d_addr : bus.i_addr;
            wdata <= bus.d_wdata;
        end
    end

    arb_word_counter #(.CNT_W(CNT_W), .TC(WORDS)) u_issue (
        .clk(clk), .rst(rst), .clr(done), .inc(bus.mem_en && fill), .cnt(issue_cnt), .tc(issue_tc)
    );
    arb_word_counter #(.CNT_W(CNT_W), .TC(WORDS)) u_ret (
        .clk(clk), .rst(rst), .clr(done), .inc(ret), .cnt(ret_cnt), .tc(ret_tc)
    );

    assign bus.mem_en = (fill && !issue_tc) || state == ARB_D_WRITE;
    assign bus.mem_wr = state == ARB_D_WRITE;
    assign bus.mem_addr = !bus.mem_en ? '0 :
        (bus.mem_wr ? base : base + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES));
    assign bus.mem_wdata = bus.mem_wr ? wdata : '0;
    assign bus.i_grant = state == ARB_I_FILL;
    assign bus.d_grant = state == ARB_D_FILL || state == ARB_D_WRITE;
    assign bus.i_rvalid = ret && state == ARB_I_FILL;
    assign bus.d_rvalid = ret && state == ARB_D_FILL;
    assign bus.rdata = ret ? bus.mem_rdata : '0;
    assign bus.i_done = done && state == ARB_I_FILL;
    assign bus.d_done = done && state != ARB_I_FILL;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter against a 2-cycle-latency memory model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    // Memory returns addr ^ 16'hA5A5 two cycles after each read issue.
    logic q0 = 1'b0, q1 = 1'b0, rv = 1'b0, spur = 1'b0;
    logic [15:0] a0 = '0, a1 = '0;
    assign bus.mem_rvalid = rv | spur;
    always @(negedge clk) begin
        rv = q1;
        bus.mem_rdata = a1 ^ 16'hA5A5;
        q1 = q0;
        a1 = a0;
        q0 = bus.mem_en && !bus.mem_wr;
        a0 = bus.mem_addr;
    end

    int cyc = 0, rd_n, wr_n, irv_n, drv_n, idone_n, ddone_n, i_done_rv, d_done_rv;
    int i_gnt_cyc, d_done_cyc, en_first, en_last, rd_bad;
    logic [15:0] rd_addr [0:31];
    always @(negedge clk) begin
        #1;
        cyc++;
        if (bus.mem_en && !bus.mem_wr && rd_n < 32) begin
            rd_addr[rd_n] = bus.mem_addr;
            if (rd_n == 0) en_first = cyc;
            en_last = cyc;
            rd_n++;
        end
        if (bus.mem_en && bus.mem_wr) wr_n++;
        if (bus.i_rvalid) irv_n++;
        if (bus.d_rvalid) drv_n++;
        if ((bus.i_rvalid || bus.d_rvalid) && bus.rdata !== bus.mem_rdata) rd_bad++;
        if (bus.i_done) begin idone_n++; i_done_rv = irv_n; end
        if (bus.d_done) begin ddone_n++; d_done_rv = drv_n; d_done_cyc = cyc; end
        if (bus.i_grant && i_gnt_cyc < 0) i_gnt_cyc = cyc;
    end

    task automatic clr_mon;
        rd_n = 0; wr_n = 0; irv_n = 0; drv_n = 0; idone_n = 0; ddone_n = 0;
        i_done_rv = 0; d_done_rv = 0; i_gnt_cyc = -1; d_done_cyc = -1;
        en_first = 0; en_last = 0; rd_bad = 0;
    endtask

    task automatic step;
        @(negedge clk);
        #2;
    endtask

    function automatic logic [55:0] outs;
        return {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.i_grant, bus.d_grant,
                bus.i_rvalid, bus.d_rvalid, bus.rdata, bus.i_done, bus.d_done};
    endfunction

    task automatic test_reset;
        rst = 1'b1; spur = 1'b1;
        repeat (2) step();
        n_chk++; if (outs() !== 56'h0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", outs()); end
        n_chk++; if (dut.issue_cnt !== 4'd0 || dut.ret_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", dut.issue_cnt, dut.ret_cnt);
        end
        spur = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_i_fill;
        clr_mon();
        bus.i_addr = 16'h0040; bus.i_req = 1'b1;
        step();
        n_chk++; if (bus.i_grant !== 1'b1 || bus.d_grant !== 1'b0) begin
            n_fail++; $display("FAIL ifill_grant: got i=%b d=%b expected i=1 d=0", bus.i_grant, bus.d_grant);
        end
        n_chk++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0040) begin
            n_fail++; $display("FAIL ifill_first_issue: got en=%b addr=%h expected en=1 addr=0040", bus.mem_en, bus.mem_addr);
        end
        for (int k = 0; k < 30 && idone_n == 0; k++) step();
        bus.i_req = 1'b0;
        n_chk++; if (rd_n !== 8) begin n_fail++; $display("FAIL ifill_issues: got %0d expected 8", rd_n); end
        for (int k = 0; k < 8; k++) begin
            n_chk++; if (rd_addr[k] !== 16'h0040 + 16'(2 * k)) begin
                n_fail++; $display("FAIL ifill_addr%0d: got %h expected %h", k, rd_addr[k], 16'h0040 + 16'(2 * k));
            end
        end
        n_chk++; if (en_last - en_first !== 7) begin n_fail++; $display("FAIL ifill_consecutive: got span %0d expected 7", en_last - en_first); end
        n_chk++; if (irv_n !== 8 || drv_n !== 0) begin n_fail++; $display("FAIL ifill_rvalid: got i=%0d d=%0d expected 8/0", irv_n, drv_n); end
        n_chk++; if (idone_n !== 1 || i_done_rv !== 8) begin
            n_fail++; $display("FAIL ifill_done: got n=%0d at valid %0d expected 1 at 8", idone_n, i_done_rv);
        end
        n_chk++; if (rd_bad !== 0) begin n_fail++; $display("FAIL ifill_rdata: got %0d bad words expected 0", rd_bad); end
        step();
        n_chk++; if (bus.i_grant !== 1'b0) begin n_fail++; $display("FAIL ifill_release: got %b expected 0", bus.i_grant); end
    endtask

    task automatic test_priority;
        clr_mon();
        bus.i_addr = 16'h0200; bus.d_addr = 16'h0100; bus.d_wr = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        step();
        n_chk++; if (bus.d_grant !== 1'b1 || bus.i_grant !== 1'b0) begin
            n_fail++; $display("FAIL prio_first: got d=%b i=%b expected d=1 i=0", bus.d_grant, bus.i_grant);
        end
        for (int k = 0; k < 30 && ddone_n == 0; k++) step();
        bus.d_req = 1'b0;
        step();
        n_chk++; if (bus.i_grant !== 1'b1) begin n_fail++; $display("FAIL prio_second: got %b expected 1", bus.i_grant); end
        n_chk++; if (i_gnt_cyc !== d_done_cyc + 1) begin
            n_fail++; $display("FAIL prio_b2b: got grant cycle %0d expected %0d", i_gnt_cyc, d_done_cyc + 1);
        end
        for (int k = 0; k < 30 && idone_n == 0; k++) step();
        bus.i_req = 1'b0;
        n_chk++; if (rd_n !== 16 || drv_n !== 8 || irv_n !== 8) begin
            n_fail++; $display("FAIL prio_counts: got %0d/%0d/%0d expected 16/8/8", rd_n, drv_n, irv_n);
        end
        n_chk++; if (rd_addr[0] !== 16'h0100 || rd_addr[7] !== 16'h010E || rd_addr[8] !== 16'h0200 || rd_addr[15] !== 16'h020E) begin
            n_fail++; $display("FAIL prio_addr: got %h %h %h %h expected 0100 010E 0200 020E", rd_addr[0], rd_addr[7], rd_addr[8], rd_addr[15]);
        end
        n_chk++; if (d_done_rv !== 8 || i_done_rv !== 8) begin
            n_fail++; $display("FAIL prio_done: got d@%0d i@%0d expected 8/8", d_done_rv, i_done_rv);
        end
        step();
    endtask

    task automatic test_store_during_fill;
        clr_mon();
        bus.i_addr = 16'h0300; bus.i_req = 1'b1;
        step();
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h1234; bus.d_wdata = 16'hBEEF;
        for (int k = 0; k < 30 && idone_n == 0; k++) step();
        n_chk++; if (idone_n !== 1 || wr_n !== 0 || bus.d_grant !== 1'b0) begin
            n_fail++; $display("FAIL store_wait: got done=%0d stores=%0d dgrant=%b expected 1/0/0", idone_n, wr_n, bus.d_grant);
        end
        bus.i_req = 1'b0;
        step();
        n_chk++; if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1) begin
            n_fail++; $display("FAIL store_strobe: got en=%b wr=%b expected 1/1", bus.mem_en, bus.mem_wr);
        end
        n_chk++; if (bus.mem_addr !== 16'h1234 || bus.mem_wdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL store_data: got %h/%h expected 1234/BEEF", bus.mem_addr, bus.mem_wdata);
        end
        n_chk++; if (bus.d_done !== 1'b1 || bus.d_grant !== 1'b1 || bus.i_grant !== 1'b0) begin
            n_fail++; $display("FAIL store_done: got done=%b dg=%b ig=%b expected 1/1/0", bus.d_done, bus.d_grant, bus.i_grant);
        end
        bus.d_req = 1'b0; bus.d_wr = 1'b0;
        step();
        n_chk++; if (bus.mem_en !== 1'b0 || bus.mem_wdata !== 16'h0 || bus.d_grant !== 1'b0 || wr_n !== 1) begin
            n_fail++; $display("FAIL store_once: got en=%b wd=%h dg=%b stores=%0d expected 0/0000/0/1", bus.mem_en, bus.mem_wdata, bus.d_grant, wr_n);
        end
    endtask

    task automatic test_spurious;
        clr_mon();
        step();
        spur = 1'b1;
        step();
        n_chk++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.rdata !== 16'h0) begin
            n_fail++; $display("FAIL spur_gate: got %b/%b/%h expected 0/0/0000", bus.i_rvalid, bus.d_rvalid, bus.rdata);
        end
        spur = 1'b0;
        step();
        n_chk++; if (dut.ret_cnt !== 4'd0 || dut.issue_cnt !== 4'd0 || irv_n !== 0 || drv_n !== 0) begin
            n_fail++; $display("FAIL spur_cnt: got ret=%0d issue=%0d rv=%0d/%0d expected all 0", dut.ret_cnt, dut.issue_cnt, irv_n, drv_n);
        end
    endtask

    task automatic test_reset_mid_fill;
        clr_mon();
        bus.d_addr = 16'h0500; bus.d_wr = 1'b0; bus.d_req = 1'b1;
        for (int k = 0; k < 30 && drv_n < 3; k++) step();
        n_chk++; if (drv_n !== 3) begin n_fail++; $display("FAIL rstfill_progress: got %0d returns expected 3", drv_n); end
        rst = 1'b1; bus.d_req = 1'b0;
        step();
        n_chk++; if (outs() !== 56'h0) begin n_fail++; $display("FAIL rstfill_outs: got %h expected 0", outs()); end
        rst = 1'b0;
        repeat (4) step();
        n_chk++; if (drv_n !== 3 || ddone_n !== 0) begin
            n_fail++; $display("FAIL rstfill_drop: got returns=%0d done=%0d expected 3/0", drv_n, ddone_n);
        end
        clr_mon();
        bus.i_addr = 16'h0600; bus.i_req = 1'b1;
        step();
        for (int k = 0; k < 30 && idone_n == 0; k++) step();
        bus.i_req = 1'b0;
        n_chk++; if (rd_n !== 8 || rd_addr[0] !== 16'h0600 || rd_addr[7] !== 16'h060E) begin
            n_fail++; $display("FAIL rstfill_refill: got n=%0d %h..%h expected 8 0600..060E", rd_n, rd_addr[0], rd_addr[7]);
        end
        n_chk++; if (irv_n !== 8 || i_done_rv !== 8 || rd_bad !== 0) begin
            n_fail++; $display("FAIL rstfill_return: got rv=%0d done@%0d bad=%0d expected 8/8/0", irv_n, i_done_rv, rd_bad);
        end
        step();
    endtask

    task automatic test_wrap_drop;
        clr_mon();
        bus.i_addr = 16'hFFF0; bus.i_req = 1'b1;
        step();
        for (int k = 0; k < 30 && idone_n == 0; k++) step();
        bus.i_req = 1'b0;
        n_chk++; if (rd_addr[0] !== 16'hFFF0 || rd_addr[7] !== 16'hFFFE || i_done_rv !== 8) begin
            n_fail++; $display("FAIL top_fill: got %h..%h done@%0d expected FFF0..FFFE 8", rd_addr[0], rd_addr[7], i_done_rv);
        end
        step();
        clr_mon();
        bus.d_addr = 16'hFFF8; bus.d_wr = 1'b0; bus.d_req = 1'b1;
        for (int k = 0; k < 20 && rd_n < 2; k++) step();
        bus.d_req = 1'b0;
        for (int k = 0; k < 30 && ddone_n == 0; k++) step();
        n_chk++; if (rd_n !== 8 || rd_addr[3] !== 16'hFFFE || rd_addr[4] !== 16'h0000 || rd_addr[7] !== 16'h0006) begin
            n_fail++; $display("FAIL wrap_addr: got n=%0d %h %h %h expected 8 FFFE 0000 0006", rd_n, rd_addr[3], rd_addr[4], rd_addr[7]);
        end
        n_chk++; if (drv_n !== 8 || ddone_n !== 1 || d_done_rv !== 8) begin
            n_fail++; $display("FAIL drop_complete: got rv=%0d done=%0d@%0d expected 8 1@8", drv_n, ddone_n, d_done_rv);
        end
        step();
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
        clr_mon();
        test_reset();
        test_i_fill();
        test_priority();
        test_store_during_fill();
        test_spurious();
        test_reset_mid_fill();
        test_wrap_drop();
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
